// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, the TX state encoding and small helpers.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_tx_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CLK_DIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // A programmed divisor of zero is treated as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        logic [15:0] result;
        if (div == 16'd0) begin
            result = 16'd1;
        end else begin
            result = div;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the oldest entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array; no reset needed since occupancy is tracked by count_r.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_interface.sv
// Memory-mapped UART transmitter (8N1, LSB first) with a byte TX FIFO,
// a STATUS register and a programmable bit-period divisor.
// Optional feature macro: UART_TX_PARITY_EN (CLK_DIV[16] enables even parity).
module uart_tx_interface
    import uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [15:0] DEFAULT_CLK_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic [3:0]  addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    fifo_data_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [8:0]    count_ext_s;
    logic [7:0]    count_field_s;
    logic          busy_s;
    logic [31:0]   rd_mux_s;
    logic [15:0]   next_period_s;
    logic          bit_end_s;
    logic          unused_s;

    logic [15:0]   clk_div_r;
    logic          overflow_r;
    logic [31:0]   read_data_r;
    logic          read_valid_r;
    tx_state_t     state_r;
    logic [15:0]   bit_cnt_r;
    logic [15:0]   period_r;
    logic [7:0]    shift_r;
    logic [2:0]    bit_idx_r;
    logic          parity_r;
    logic          tx_r;
`ifdef UART_TX_PARITY_EN
    logic          parity_en_r;
`endif

    assign reg_sel_s       = addr[3:2];
    assign unused_s        = ^{addr[1:0], write_data[31:16], byte_enable[3:2]};
    assign wr_acc_s        = write_req && ready;
    assign rd_acc_s        = read_req && ready;
    assign push_s          = wr_acc_s && (reg_sel_s == REG_DATA) && byte_enable[0];
    assign pop_s           = (state_r == ST_IDLE) && !fifo_empty_s;
    assign busy_s          = (state_r != ST_IDLE) || !fifo_empty_s;
    assign next_period_s   = eff_div(clk_div_r);
    assign bit_end_s       = (bit_cnt_r == (period_r - 16'd1));
    assign read_data       = read_data_r;
    assign read_data_valid = read_valid_r;
    assign tx              = tx_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (write_data[7:0]),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Only a DATA write against a full FIFO is back-pressured.
    always_comb begin
        ready = 1'b1;
        if (write_req && (reg_sel_s == REG_DATA) && fifo_full_s) begin
            ready = 1'b0;
        end else begin
            ready = 1'b1;
        end
    end

    // STATUS count field is 8 bits; a 256-deep FIFO saturates at 255.
    always_comb begin
        count_ext_s = 9'(fifo_count_s);
        if (count_ext_s[8]) begin
            count_field_s = 8'hFF;
        end else begin
            count_field_s = count_ext_s[7:0];
        end
    end

    // Read mux over the register map, using pre-write values.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (reg_sel_s)
            REG_STATUS: begin
                rd_mux_s = {16'h0000, count_field_s, 4'h0,
                            overflow_r, busy_s, fifo_empty_s, fifo_full_s};
            end
            REG_CLK_DIV: begin
`ifdef UART_TX_PARITY_EN
                rd_mux_s = {15'h0000, parity_en_r, clk_div_r};
`else
                rd_mux_s = {16'h0000, clk_div_r};
`endif
            end
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Registered read response with fixed one-cycle latency; zero when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_r  <= 32'h0000_0000;
            read_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
            read_data_r  <= rd_mux_s;
            read_valid_r <= 1'b1;
        end else begin
            read_data_r  <= 32'h0000_0000;
            read_valid_r <= 1'b0;
        end
    end

    // Writable control state: divisor lanes, parity enable and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_div_r   <= DEFAULT_CLK_DIV;
            overflow_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_en_r <= 1'b0;
`endif
        end else begin
            if (wr_acc_s && (reg_sel_s == REG_CLK_DIV)) begin
                if (byte_enable[0]) begin
                    clk_div_r[7:0] <= write_data[7:0];
                end
                if (byte_enable[1]) begin
                    clk_div_r[15:8] <= write_data[15:8];
                end
`ifdef UART_TX_PARITY_EN
                if (byte_enable[2]) begin
                    parity_en_r <= write_data[16];
                end
`endif
            end
            // A push into a full FIFO cannot happen because ready drops first.
            if (push_s && fifo_full_s) begin
                overflow_r <= 1'b1;
            end else if (wr_acc_s && (reg_sel_s == REG_STATUS) &&
                         byte_enable[0] && write_data[STAT_OVERFLOW]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Serialiser: start, 8 data bits LSB first, optional parity, stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 16'd0;
            period_r  <= 16'd1;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 16'd0;
                    if (!fifo_empty_s) begin
                        shift_r   <= fifo_data_s;
                        parity_r  <= even_parity(fifo_data_s);
                        period_r  <= next_period_s;
                        bit_idx_r <= 3'd0;
                        tx_r      <= 1'b0;
                        state_r   <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        period_r  <= next_period_s;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        period_r  <= next_period_s;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (parity_en_r) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
`else
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        period_r  <= next_period_s;
                        tx_r      <= 1'b1;
                        state_r   <= ST_STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        tx_r      <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                default: begin
                    bit_cnt_r <= 16'd0;
                    tx_r      <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
